// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32I fetch stage: PC, credit-limited imem requests, decode FIFO, redirect flush.
// Define IFU_PERF_CNT_EN to add the perf_fetched/perf_flushed counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        fetch_fault
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

  typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_t;

  state_t        state_q, state_n;
  logic [31:0]   fetch_pc_q;
  logic [CW-1:0] count_q, inflight_q, drop_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q, tag_rd_q, tag_wr_q;
  logic          fault_q;

  logic [31:0]   fifo_instr [BUF_DEPTH];
  logic [31:0]   fifo_pc    [BUF_DEPTH];
  logic [31:0]   tag_mem    [BUF_DEPTH];

  logic          redir_ok, redir_bad, flush, req_ok;
  logic          accept, rsp_any, rsp_live, push, hs, pop;
  logic [CW:0]   credit_used;
  logic [CW-1:0] count_after_pop, count_n, inflight_n, drop_n;
  logic [PW-1:0] rd_ptr_n;
  logic          head_load;
  logic [31:0]   head_instr_n, head_pc_n;

  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    redir_ok  = 1'b0;
    redir_bad = 1'b0;
    req_ok    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          if (redirect_pc[1:0] == 2'b00) begin
            redir_ok = 1'b1;
          end else begin
            redir_bad = 1'b1;
            state_n   = ST_FAULT;
          end
        end else begin
          req_ok = credit_used < DEPTH_W;
        end
      end
      default: ;
    endcase
  end

  // Request is masked during reset so the port reads idle while rst is high.
  assign flush          = redir_ok | redir_bad;
  assign imem_req_valid = req_ok & ~rst;
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid & imem_req_ready;
  assign id_valid       = (state_q == ST_RUN) && (count_q != '0);
  assign hs             = id_valid & id_ready;
  assign pop            = hs & ~flush;
  assign rsp_any        = imem_rsp_valid & (inflight_q != '0);
  assign rsp_live       = rsp_any & (drop_q == '0);
  assign push           = rsp_live & (state_q == ST_RUN) & ~flush;
  assign fetch_fault    = fault_q;

  assign count_after_pop = count_q - CW'(pop);
  assign count_n         = flush ? '0 : count_after_pop + CW'(push);
  assign rd_ptr_n        = flush ? '0 : rd_ptr_q + PW'(pop);
  assign inflight_n      = inflight_q + CW'(accept) - CW'(rsp_any);

  // Everything still in flight at a flush is stale, including earlier stale ones.
  always_comb begin
    drop_n = drop_q;
    if (flush)
      drop_n = inflight_q - CW'(rsp_any);
    else if (rsp_any && (drop_q != '0))
      drop_n = drop_q - CW'(1);
  end

  always_comb begin
    head_load    = 1'b0;
    head_instr_n = id_instr;
    head_pc_n    = id_pc;
    if (!flush) begin
      if (push && (count_after_pop == '0)) begin
        head_load    = 1'b1;
        head_instr_n = imem_rsp_data;
        head_pc_n    = tag_mem[tag_rd_q];
      end else if (count_n != '0) begin
        head_load    = 1'b1;
        head_instr_n = fifo_instr[rd_ptr_n];
        head_pc_n    = fifo_pc[rd_ptr_n];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      fault_q    <= 1'b0;
      id_instr   <= '0;
      id_pc      <= '0;
    end else begin
      count_q    <= count_n;
      inflight_q <= inflight_n;
      drop_q     <= drop_n;
      rd_ptr_q   <= rd_ptr_n;
      if (redir_ok)
        fetch_pc_q <= redirect_pc;
      else if (accept)
        fetch_pc_q <= fetch_pc_q + 32'd4;
      if (redir_bad)
        fault_q <= 1'b1;
      if (flush) begin
        wr_ptr_q <= '0;
        tag_rd_q <= '0;
        tag_wr_q <= '0;
      end else begin
        if (push)     wr_ptr_q <= wr_ptr_q + PW'(1);
        if (accept)   tag_wr_q <= tag_wr_q + PW'(1);
        if (rsp_live) tag_rd_q <= tag_rd_q + PW'(1);
      end
      if (head_load) begin
        id_instr <= head_instr_n;
        id_pc    <= head_pc_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr_q] <= imem_rsp_data;
      fifo_pc[wr_ptr_q]    <= tag_mem[tag_rd_q];
    end
    if (accept)
      tag_mem[tag_wr_q] <= fetch_pc_q;
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (hs)
        perf_fetched <= perf_fetched + 32'd1;
      if (flush)
        perf_flushed <= perf_flushed + 32'(count_q - CW'(hs)) + 32'(inflight_q - drop_q);
    end
  end
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage of the RV32I core. It sits directly upstream of decode/imm_gen.
- Owns the PC register and issues word fetches to instruction memory over a valid/ready request channel with variable-latency, in-order responses.
- Buffers returned instructions in a small FIFO and presents {instr, pc} to decode via a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; must be 4-byte aligned.
- BUF_DEPTH, 2, FIFO entries and maximum in-flight credit; legal values 2 or 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response data valid; responses arrive in request order, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  fetched instruction word.
- redirect_valid  input  1  branch/jump taken; a one-cycle pulse.
- redirect_pc  input  32  new fetch target.
- id_valid  output  1  FIFO head holds a valid instruction.
- id_ready  input  1  decode consumes the head this cycle.
- id_instr  output  32  instruction at the FIFO head.
- id_pc  output  32  PC of id_instr.
- fetch_fault  output  1  misaligned redirect detected; sticky until reset.

Behaviour:
- Reset values (asynchronous):
  - fetch_pc = RESET_PC; FIFO count = 0; inflight = 0; drop_cnt = 0; state = RUN.
  - Outputs: imem_req_valid = 0, id_valid = 0, id_instr = 0, id_pc = 0, fetch_fault = 0.
- States: RUN, FAULT.
- RUN, request issue:
  - imem_req_valid = 1 when (count + inflight) < BUF_DEPTH and no redirect is this cycle.
  - imem_req_addr = fetch_pc.
  - On acceptance (valid & ready): fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000); inflight += 1.
  - The address of each accepted request is pushed into a PC tag queue of depth BUF_DEPTH.
- Responses:
  - Each imem_rsp_valid pops the tag queue and decrements inflight.
  - If drop_cnt > 0: the response is discarded and drop_cnt -= 1.
  - Otherwise {rsp_data, tag} is written to the FIFO tail.
  - The credit rule guarantees the FIFO never overflows.
- Decode side:
  - id_valid = (count != 0); id_instr and id_pc are driven registered from the FIFO head.
  - Head pops when id_valid & id_ready.
  - Push and pop in the same cycle leave count unchanged.
  - When the FIFO is empty, id_instr and id_pc hold their last values.
- Redirect (redirect_valid = 1, redirect_pc[1:0] == 0), priority over everything else in that cycle:
  - FIFO is flushed (count = 0); any same-cycle id pop or response write is ignored.
  - drop_cnt = inflight minus any response arriving this cycle; the tag queue is cleared to match.
  - fetch_pc = redirect_pc; no request is issued in the redirect cycle.
  - Earliest request to the new target is the next cycle, with imem_req_addr = redirect_pc.
  - Latency from redirect to id_valid = 1 + memory latency + 1 (FIFO register).
- Misaligned redirect (redirect_pc[1:0] != 0):
  - fetch_fault = 1 and the FIFO is flushed; state goes to FAULT.
- FAULT state:
  - imem_req_valid = 0; id_valid = 0; outstanding responses are drained and discarded.
  - Only reset exits FAULT.
- Request holding:
  - Once imem_req_valid is asserted, imem_req_addr stays stable until acceptance or redirect.
  - A redirect may withdraw an unaccepted request.
- Reset mid-operation: all state clears immediately. Responses to pre-reset requests are not expected; the memory is reset on the same rst.

Optional Feature:
Macro IFU_PERF_CNT_EN.
- Defined: adds output ports perf_fetched[31:0] and perf_flushed[31:0], both reset to 0 and wrapping at 2^32.
  - perf_fetched increments on each id_valid & id_ready.
  - perf_flushed increments by the number of FIFO entries plus in-flight responses discarded per redirect.
- Undefined: the ports and counters are absent; functional behaviour is identical.

Test Plan:
- Reset release, memory ready = 1, latency 1, id_ready = 1:
  - imem_req_addr sequence is 0x0, 0x4, 0x8, ...
  - id_valid first rises 2 cycles after the first acceptance with id_pc = 0x0.
  - id_instr matches the memory word at each PC.
- id_ready = 0 from reset with BUF_DEPTH = 2:
  - Exactly 2 requests accepted (0x0, 0x4), then imem_req_valid = 0.
  - count = 2; id_pc holds 0x0.
  - Releasing id_ready resumes requests at 0x8.
- Memory latency 3 with 2 in flight, redirect to 0x100:
  - Both stale responses are dropped; the next request is 0x100.
  - First id_pc = 0x100; no 0x8/0xC ever reaches decode.
- Redirect in the same cycle as id_valid & id_ready and rsp_valid:
  - The FIFO ends empty; the popped instruction is the only one consumed.
  - The arriving response is discarded and drop_cnt counts it correctly.
- Redirect to 0x102:
  - fetch_fault = 1 and id_valid = 0; no further requests.
  - Asserting rst clears the fault and restarts at RESET_PC.
- fetch_pc = 0xFFFF_FFFC accepted:
  - Next imem_req_addr = 0x0000_0000.
  - Asserting rst mid-fetch drives all outputs to their reset values in the same cycle (asynchronously).
